mmio_bus_bridge: RTL and testbench
==================================

Name: mmio_bus_bridge

Overview:
Parametrised successor to the CPU memory-mapped bus. It accepts one 32-bit CPU request at a time (RD32/WR8/WR16/WR32, EN_N/READY handshake) and decodes it against NUM_SLAVES configurable address regions. It splits the request into LANE_W-wide beats to one slave channel. Unlike the previous bus, it supports per-slave wait states (s_ready), a decode/timeout error flag, and generic region count and lane width. It sits between the CPU core and cache/LED/VGA/VGA-ctrl/keyboard slaves.

Parameters:
NUM_SLAVES, 5, number of slave channels/regions
ADDR_W, 32, address width
DATA_W, 32, CPU data width; must be a multiple of LANE_W
LANE_W, 16, slave data width; BEATS = DATA_W/LANE_W
REGION_BASE, pkg default map, NUM_SLAVES*ADDR_W flattened base addresses; slave i at [i*ADDR_W +: ADDR_W]
REGION_SIZE, pkg default map, NUM_SLAVES*ADDR_W flattened region sizes in bytes
TIMEOUT, 255, max wait cycles per beat before error; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  CPU byte address
wdata  in  DATA_W  CPU write data
WLEN  in  2  00 RD32, 01 WR8, 10 WR16, 11 WR32
EN_N  in  1  request strobe, active low, sampled in IDLE
READY  out  1  bridge idle / request complete
rdata  out  DATA_W  read data
err  out  1  last request failed (decode miss or timeout)
s_en  out  NUM_SLAVES  one-hot slave select
s_wen  out  1  write strobe for the current beat
s_addr  out  ADDR_W  region-local byte address of the current beat, LSB 0
s_wdata  out  LANE_W  beat write data
s_rdata  in  NUM_SLAVES*LANE_W  flattened slave read data
s_ready  in  NUM_SLAVES  per-slave beat acknowledge

Behaviour:
- Reset (async): state IDLE, READY=1, rdata=0, err=0, s_en=0, s_wen=0, s_addr=0, s_wdata=0, beat and timeout counters at 0. Reset mid-request aborts the request and emits no further strobes.
- Capture: in IDLE, at a posedge with EN_N=0, latch address, wdata, WLEN, decoded index; READY<=0, err<=0. EN_N is ignored outside IDLE.
- Decode: hit_i = base_i <= address < base_i+size_i. On overlap the lowest index wins. Decode uses the start address only; later beats stay on the same slave.
- Miss: go to ERR for 1 cycle, then IDLE with READY=1, err=1, rdata unchanged. No s_en is issued.
- States: IDLE, RD_BEAT, RMW_RD, WR_BEAT, ERR.
- Beat rule: during a beat state, s_en[idx]=1 and s_addr=(address-base_idx) with LSB cleared, plus beat*LANE_W/8. The beat completes at the posedge where s_ready[idx]=1. s_rdata is valid in that same cycle.
- RD32: BEATS RD_BEAT beats. Beat k loads rdata[k*LANE_W +: LANE_W].
- WR16: one WR_BEAT, s_wen=1, s_wdata=wdata[LANE_W-1:0].
- WR32: BEATS WR_BEATs. Beat k drives wdata[k*LANE_W +: LANE_W].
- WR8: RMW_RD reads the lane, then WR_BEAT writes the merged lane. address[0]=1 replaces the byte at [15:8]; address[0]=0 replaces [7:0]. The other byte is kept.
- Alignment: address bit 0 is ignored for RD32/WR16/WR32.
- Completion: on the last beat's acknowledge edge, state<=IDLE and READY<=1 in the same edge.
- Latency: with zero wait states, READY is low for exactly BEATS cycles (RD32/WR32), 1 (WR16), 2 (WR8).
- Back-to-back: if EN_N is still low in IDLE, the next request is captured on the next edge, so READY is high for 1 cycle minimum.
- Timeout: the counter resets per beat. If TIMEOUT consecutive non-ready cycles pass, go to ERR and then IDLE with err=1. Writes already done are not rolled back; rdata lanes already read are kept.
- s_wen is asserted only in WR_BEAT; s_en is never multi-hot.

Decomposition:
- mmio_bus_pkg: WLEN codes, state encoding, default region map. Map: cache 0x0/0x80000, LED 0x80000/0x4, VGA 0x80004/0x12C0, VGA ctrl 0x812C4/0x10, KB 0x812D4/0x10.
- Sub-module mmio_addr_decoder: combinational region compare giving hit, one-hot select, index, and local offset.

Test Plan:
- RD32 at 0x100, cache slave zero-wait returns 0xBEEF then 0xDEAD -> rdata=0xDEADBEEF; s_addr 0x100 then 0x102; READY low 2 cycles; err=0.
- WR8 0xAB to 0x80001, LED lane holds 0x1234 -> RMW read, then write 0xAB34 at s_addr 0x0; READY low 2 cycles.
- WR32 0x11223344 to 0x80010, VGA slave s_ready delayed 3 cycles per beat -> writes 0x3344 @0xC, then 0x1122 @0xE; READY low 8 cycles.
- Access 0x00900000 (unmapped) -> no s_en, READY returns after 1 cycle with err=1, rdata unchanged.
- Slave never acknowledges with TIMEOUT=4 -> err=1 after 4 wait cycles; next request clears err.
- reset_n pulsed low mid-RD32 -> s_en=0, READY=1, rdata=0 immediately; next request completes normally.

Source files
------------

// File: rtl/mmio_bus_pkg.sv
// mmio_bus_pkg: shared definitions for the MMIO bus bridge.
//   - wlen_e  : CPU transfer-length codes carried on WLEN
//   - state_e : bridge sequencing states
//   - DEF_REGION_BASE / DEF_REGION_SIZE : default five-slave address map
//     (cache, LED, VGA, VGA ctrl, keyboard), slave i at [i*32 +: 32]
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    WLEN_RD32 = 2'b00,
    WLEN_WR8  = 2'b01,
    WLEN_WR16 = 2'b10,
    WLEN_WR32 = 2'b11
  } wlen_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_BEAT = 3'd1,
    ST_RMW_RD  = 3'd2,
    ST_WR_BEAT = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  localparam int DEF_NUM_SLAVES = 5;
  localparam int DEF_ADDR_W     = 32;

  // Index 0 sits in the least significant word.
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_REGION_BASE = {
    32'h0008_12D4,  // keyboard
    32'h0008_12C4,  // VGA ctrl
    32'h0008_0004,  // VGA
    32'h0008_0000,  // LED
    32'h0000_0000   // cache
  };

  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_REGION_SIZE = {
    32'h0000_0010,
    32'h0000_0010,
    32'h0000_12C0,
    32'h0000_0004,
    32'h0008_0000
  };

endpackage

// File: rtl/mmio_addr_decoder.sv
// mmio_addr_decoder: combinational region lookup for the bus bridge.
// Ports:
//   addr_i   in  ADDR_W      byte address to decode
//   hit_o    out 1           address falls in some region
//   sel_o    out NUM_SLAVES  one-hot select of the winning region
//   idx_o    out IDX_W       index of the winning region
//   offset_o out ADDR_W      address relative to the winning region base
module mmio_addr_decoder
  import mmio_bus_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int IDX_W      = 3,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_SIZE = DEF_REGION_SIZE
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  hit_o,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [ADDR_W-1:0]     offset_o
);

  logic [ADDR_W-1:0] base_w;
  logic [ADDR_W-1:0] size_w;

  // Scan from the highest index down so the lowest matching index is the
  // last one written and therefore wins on overlap. The compare uses
  // (addr - base) < size so a region ending at the top of the address
  // space does not overflow.
  always_comb begin
    hit_o    = 1'b0;
    sel_o    = '0;
    idx_o    = '0;
    offset_o = '0;
    base_w   = '0;
    size_w   = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      base_w = REGION_BASE[i*ADDR_W +: ADDR_W];
      size_w = REGION_SIZE[i*ADDR_W +: ADDR_W];
      if ((addr_i >= base_w) && ((addr_i - base_w) < size_w)) begin
        hit_o    = 1'b1;
        sel_o    = '0;
        sel_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        offset_o = addr_i - base_w;
      end
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: single-outstanding CPU-to-slave MMIO bridge.
// Accepts RD32/WR8/WR16/WR32 requests, decodes them to one slave region and
// issues LANE_W-wide beats with per-slave wait states and a per-beat timeout.
// Ports:
//   clk, reset_n           clock / asynchronous active-low reset
//   address, wdata, WLEN   CPU request (WLEN: 00 RD32 01 WR8 10 WR16 11 WR32)
//   EN_N                   request strobe (active low, sampled in IDLE)
//   READY, rdata, err      bridge idle, read data, last request failed
//   s_en, s_wen            one-hot slave select, beat write strobe
//   s_addr, s_wdata        region-local beat address, beat write data
//   s_rdata, s_ready       flattened slave read data, per-slave acknowledge
module mmio_bus_bridge
  import mmio_bus_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = 32,
  parameter int LANE_W     = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_SIZE = DEF_REGION_SIZE,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [1:0]                   WLEN,
  input  logic                         EN_N,
  output logic                         READY,
  output logic [DATA_W-1:0]            rdata,
  output logic                         err,
  output logic [NUM_SLAVES-1:0]        s_en,
  output logic                         s_wen,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [LANE_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*LANE_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int BEATS = DATA_W / LANE_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0]       off_q, off_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  wlen_e                   wlen_q, wlen_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic                    bhi_q, bhi_d;

  logic                    dec_hit;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic [IDX_W-1:0]        dec_idx;
  logic [ADDR_W-1:0]       dec_off;

  logic                    ack;
  logic                    last_beat;
  logic [LANE_W-1:0]       lane_rd;
  logic [LANE_W-1:0]       merged;
  logic [LANE_W-1:0]       wr_lane;
  logic [ADDR_W-1:0]       beat_addr;

  mmio_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .REGION_BASE(REGION_BASE),
    .REGION_SIZE(REGION_SIZE)
  ) u_dec (
    .addr_i  (address),
    .hit_o   (dec_hit),
    .sel_o   (dec_sel),
    .idx_o   (dec_idx),
    .offset_o(dec_off)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      wlen_q  <= WLEN_RD32;
      sel_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      lane_q  <= '0;
      bhi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      wlen_q  <= wlen_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      lane_q  <= lane_d;
      bhi_q   <= bhi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    wlen_d  = wlen_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    lane_d  = lane_q;
    bhi_d   = bhi_q;
    s_en    = '0;
    s_wen   = 1'b0;
    s_addr  = '0;
    s_wdata = '0;

    ack       = |(sel_q & s_ready);
    lane_rd   = s_rdata[idx_q*LANE_W +: LANE_W];
    beat_addr = off_q + ADDR_W'(beat_q) * ADDR_W'(LANE_W / 8);
    last_beat = ((wlen_q == WLEN_RD32) || (wlen_q == WLEN_WR32)) ?
                (beat_q == BEAT_LAST) : 1'b1;

    // Byte write: keep the lane read back in RMW_RD, replace the addressed byte.
    merged = lane_q;
    merged[bhi_q*8 +: 8] = wdata_q[7:0];

    case (wlen_q)
      WLEN_WR8:  wr_lane = merged;
      WLEN_WR16: wr_lane = wdata_q[LANE_W-1:0];
      default:   wr_lane = wdata_q[beat_q*LANE_W +: LANE_W];
    endcase

    case (state_q)
      ST_IDLE: begin
        if (!EN_N) begin
          off_d   = {dec_off[ADDR_W-1:1], 1'b0};
          bhi_d   = address[0];
          wdata_d = wdata;
          wlen_d  = wlen_e'(WLEN);
          sel_d   = dec_sel;
          idx_d   = dec_idx;
          beat_d  = '0;
          tmo_d   = '0;
          ready_d = 1'b0;
          err_d   = 1'b0;
          if (!dec_hit) begin
            state_d = ST_ERR;
          end else begin
            case (wlen_e'(WLEN))
              WLEN_RD32: state_d = ST_RD_BEAT;
              WLEN_WR8:  state_d = ST_RMW_RD;
              default:   state_d = ST_WR_BEAT;
            endcase
          end
        end
      end

      ST_RD_BEAT, ST_RMW_RD, ST_WR_BEAT: begin
        s_en   = sel_q;
        s_addr = beat_addr;
        if (state_q == ST_WR_BEAT) begin
          s_wen   = 1'b1;
          s_wdata = wr_lane;
        end
        if (ack) begin
          tmo_d = '0;
          if (state_q == ST_RMW_RD) begin
            lane_d  = lane_rd;
            state_d = ST_WR_BEAT;
          end else begin
            if (state_q == ST_RD_BEAT) begin
              rdata_d[beat_q*LANE_W +: LANE_W] = lane_rd;
            end
            if (last_beat) begin
              state_d = ST_IDLE;
              ready_d = 1'b1;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end else if (TIMEOUT != 0) begin
          // tmo_q counts non-ready cycles already elapsed in this beat.
          if (tmo_q == TMO_LAST) begin
            state_d = ST_ERR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      ST_ERR: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        err_d   = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign READY = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Self-checking bench for mmio_bus_bridge: directed scenarios followed by
// randomized requests, compared against a transaction-level model that works
// on region tables and lane-addressed slave memories.
module tb_mmio_bus_bridge;

  localparam int NS  = 5;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 16;
  localparam int TMO = 4;

  localparam logic [31:0] RBASE [NS] = '{32'h0, 32'h80000, 32'h80004, 32'h812C4, 32'h812D4};
  localparam logic [31:0] RSIZE [NS] = '{32'h80000, 32'h4, 32'h12C0, 32'h10, 32'h10};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic [DW-1:0]     wdata;
  logic [1:0]        WLEN;
  logic              EN_N;
  logic              READY;
  logic [DW-1:0]     rdata;
  logic              err;
  logic [NS-1:0]     s_en;
  logic              s_wen;
  logic [AW-1:0]     s_addr;
  logic [LW-1:0]     s_wdata;
  logic [NS*LW-1:0]  s_rdata;
  logic [NS-1:0]     s_ready;

  mmio_bus_bridge #(.TIMEOUT(TMO)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .address(address),
    .wdata  (wdata),
    .WLEN   (WLEN),
    .EN_N   (EN_N),
    .READY  (READY),
    .rdata  (rdata),
    .err    (err),
    .s_en   (s_en),
    .s_wen  (s_wen),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_rdata(s_rdata),
    .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int prot_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int i, input int j);
    return 16'(i * 4099 + j * 517 + 4660);
  endfunction

  // ---------------- slave models (wait states, lane memories) ----------------
  logic [15:0] smem [NS][64];
  int          cnt  [NS];
  int          wt   [NS];
  logic        mem_init;

  always_comb begin
    s_rdata = '0;
    s_ready = '0;
    for (int i = 0; i < NS; i++) begin
      s_rdata[i*LW +: LW] = smem[i][s_addr[6:1]];
      s_ready[i] = s_en[i] && (cnt[i] >= wt[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      cnt[i] <= (s_en[i] && !s_ready[i]) ? cnt[i] + 1 : 0;
      if (s_en[i] && s_ready[i] && s_wen) smem[i][s_addr[6:1]] <= s_wdata;
    end
    if (mem_init) begin
      for (int i = 0; i < NS; i++)
        for (int j = 0; j < 64; j++) smem[i][j] <= init_val(i, j);
    end
  end

  always @(negedge clk) begin
    if (reset_n && (($countones(s_en) > 1) || (s_wen && (s_en == '0)))) prot_err++;
  end

  // ---------------- reference model ----------------
  logic [15:0] rmem [NS][64];
  logic [31:0] ref_rdata;
  logic        ref_err;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if (64'(a) >= 64'(RBASE[i]) && 64'(a) < 64'(RBASE[i]) + 64'(RSIZE[i])) return i;
    end
    return -1;
  endfunction

  // Predicts final rdata/err/memory, READY-low cycle count and beat count.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                       output int ecyc, output int ebeats);
    int s, wc, off, l0, l1;
    logic [15:0] lane;
    s = ref_decode(a);
    ebeats = 0;
    ref_err = 1'b1;
    if (s < 0) begin
      ecyc = 1;
      return;
    end
    wc = wt[s];
    if (wc >= TMO) begin
      ecyc = TMO + 1;
      return;
    end
    ref_err = 1'b0;
    off = int'(a - RBASE[s]) & ~1;
    l0 = (off >> 1) & 63;
    l1 = ((off + 2) >> 1) & 63;
    case (w)
      2'b00: begin
        ref_rdata = {rmem[s][l1], rmem[s][l0]};
        ecyc = 2 * (wc + 1); ebeats = 2;
      end
      2'b01: begin
        lane = rmem[s][l0];
        if (a[0]) lane[15:8] = d[7:0];
        else      lane[7:0]  = d[7:0];
        rmem[s][l0] = lane;
        ecyc = 2 * (wc + 1); ebeats = 2;
      end
      2'b10: begin
        rmem[s][l0] = d[15:0];
        ecyc = wc + 1; ebeats = 1;
      end
      default: begin
        rmem[s][l0] = d[15:0];
        rmem[s][l1] = d[31:16];
        ecyc = 2 * (wc + 1); ebeats = 2;
      end
    endcase
  endtask

  // ---------------- request driver with beat log ----------------
  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        wen;
    logic [15:0] data;
  } beat_t;
  beat_t blog[$];

  function automatic beat_t get_beat(input int k);
    beat_t b;
    b = '{-1, 32'hFFFF_FFFF, 1'b0, 16'h0};
    if (k < blog.size()) b = blog[k];
    return b;
  endfunction

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                        output int cyc);
    beat_t b;
    blog.delete();
    @(negedge clk);
    address = a; wdata = d; WLEN = w; EN_N = 1'b0;
    @(negedge clk);
    EN_N = 1'b1;
    cyc = 0;
    while (!READY && cyc < 200) begin
      if (|(s_en & s_ready)) begin
        b.idx = -1;
        for (int i = 0; i < NS; i++) if (s_en[i]) b.idx = i;
        b.addr = s_addr; b.wen = s_wen; b.data = s_wdata;
        blog.push_back(b);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] w);
    int ecyc, ebeats, cyc;
    model(a, d, w, ecyc, ebeats);
    do_req(a, d, w, cyc);
    chk({tag, " ready_low_cycles"}, 64'(cyc), 64'(ecyc));
    chk({tag, " err"}, 64'(err), 64'(ref_err));
    chk({tag, " rdata"}, 64'(rdata), 64'(ref_rdata));
    chk({tag, " beats"}, 64'(blog.size()), 64'(ebeats));
  endtask

  initial begin
    beat_t b;
    int mism;
    reset_n = 1'b0; mem_init = 1'b1; EN_N = 1'b1;
    address = '0; wdata = '0; WLEN = 2'b00;
    for (int i = 0; i < NS; i++) begin
      wt[i] = 0;
      for (int j = 0; j < 64; j++) rmem[i][j] = init_val(i, j);
    end
    ref_rdata = '0; ref_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset READY", 64'(READY), 64'd1);
    chk("reset rdata", 64'(rdata), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset s_en", 64'(s_en), 64'd0);
    chk("reset s_wen", 64'(s_wen), 64'd0);
    chk("reset s_addr", 64'(s_addr), 64'd0);
    chk("reset s_wdata", 64'(s_wdata), 64'd0);
    mem_init = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Cache write then read back as two lanes.
    run_op("wr32_cache", 32'h100, 32'hDEADBEEF, 2'b11);
    run_op("rd32_cache", 32'h100, 32'h0, 2'b00);
    chk("rd32 value", 64'(rdata), 64'hDEADBEEF);
    b = get_beat(0); chk("rd32 beat0 addr", 64'(b.addr), 64'h100);
    b = get_beat(1); chk("rd32 beat1 addr", 64'(b.addr), 64'h102);
    chk("rd32 beat1 slave", 64'(b.idx), 64'd0);

    // LED byte write merges into existing lane.
    run_op("wr16_led", 32'h80000, 32'h1234, 2'b10);
    run_op("wr8_led", 32'h80001, 32'hAB, 2'b01);
    b = get_beat(0); chk("wr8 rmw read wen", 64'(b.wen), 64'd0);
    chk("wr8 slave", 64'(b.idx), 64'd1);
    b = get_beat(1); chk("wr8 write addr", 64'(b.addr), 64'h0);
    chk("wr8 write data", 64'(b.data), 64'hAB34);

    // VGA with three wait states per beat.
    wt[2] = 3;
    run_op("wr32_vga_wait", 32'h80010, 32'h11223344, 2'b11);
    b = get_beat(0); chk("vga beat0 addr", 64'(b.addr), 64'hC);
    chk("vga beat0 data", 64'(b.data), 64'h3344);
    b = get_beat(1); chk("vga beat1 addr", 64'(b.addr), 64'hE);
    chk("vga beat1 data", 64'(b.data), 64'h1122);
    wt[2] = 0;

    // Unmapped address and region boundaries.
    run_op("miss", 32'h0090_0000, 32'h0, 2'b00);
    run_op("miss_after_kb", 32'h812E4, 32'h5555, 2'b10);
    run_op("last_led_byte", 32'h80003, 32'h77, 2'b01);
    run_op("first_vga", 32'h80004, 32'h0, 2'b00);

    // Dead slave times out; next request clears err.
    wt[0] = 1000;
    run_op("timeout", 32'h40, 32'h0, 2'b00);
    wt[0] = 0;
    run_op("after_timeout", 32'h100, 32'h0, 2'b00);

    // Reset in the middle of a read.
    wt[2] = 3;
    @(negedge clk);
    address = 32'h80004; WLEN = 2'b00; EN_N = 1'b0;
    @(negedge clk);
    EN_N = 1'b1;
    @(negedge clk);
    chk("midreset pre s_en", 64'(s_en), 64'b00100);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset s_en", 64'(s_en), 64'd0);
    chk("midreset READY", 64'(READY), 64'd1);
    chk("midreset rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ref_rdata = '0; ref_err = 1'b0;
    wt[2] = 0;
    run_op("after_reset", 32'h80004, 32'h0, 2'b00);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int s, lim;
      logic [31:0] a, d;
      logic [1:0] w;
      for (int i = 0; i < NS; i++) wt[i] = int'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) wt[$urandom_range(0, NS - 1)] = 1000;
      s = int'($urandom_range(0, NS));
      if (s == NS) begin
        a = ($urandom_range(0, 1) == 1) ? 32'h812E4 + ($urandom & 32'hFF)
                                        : 32'h0090_0000 + ($urandom & 32'hFFFF);
      end else begin
        lim = (RSIZE[s] < 32'd128) ? int'(RSIZE[s]) : 128;
        if ($urandom_range(0, 3) == 0) a = RBASE[s] + RSIZE[s] - 32'd1;
        else a = RBASE[s] + $urandom_range(0, lim - 1);
      end
      d = $urandom;
      w = 2'($urandom_range(0, 3));
      run_op("rnd", a, d, w);
    end

    mism = 0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < 64; j++) if (smem[i][j] !== rmem[i][j]) mism++;
    chk("final memory mismatching lanes", 64'(mism), 64'd0);
    chk("protocol violations", 64'(prot_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
